syn_seg_scan: RTL
=================

SYN_SEG_SCAN -- requirements
Module: syn_seg_scan

Interface
REQ-001 Parameter ScanDiv, default 50000, clock cycles per digit slot (legal range 1..65535).
REQ-002 Parameter LeadBlank, default 1, 1 = leading-zero blanking enabled.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data  input  32  value to display (CPU display word), eight hex nibbles.
REQ-006 halt  input  1  CPU halted indicator.
REQ-007 freeze  input  1  1 = hold the currently latched frame value.
REQ-008 an_n  output  8  digit anodes, active-low, one-hot; bit i = digit i (digit 0 rightmost).
REQ-009 seg_n  output  7  segments, active-low; bit0 = a … bit6 = g.
REQ-010 dp_n  output  1  decimal point, active-low.

Function
REQ-011 A prescaler SHALL count 0..ScanDiv-1 and wrap to 0; tick = prescaler equals ScanDiv-1; ScanDiv=1 SHALL tick every cycle.
REQ-012 On tick, digit index idx (3 bits) SHALL increment; 7 SHALL wrap to 0.
REQ-013 Frame register data_q SHALL load data on the tick where idx wraps 7->0, only if freeze=0; otherwise it holds.
REQ-014 data changes between frame loads SHALL NOT alter displayed digits (no tearing).
REQ-015 Nibble for digit idx SHALL be data_q[4*idx+3 : 4*idx].
REQ-016 Decode (gfedcba, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-017 With LeadBlank=1, digit idx>0 SHALL be blank (seg_n=7F) when data_q[31:4*idx]==0; digit 0 SHALL never blank.
REQ-018 dp_n SHALL be 0 only when idx==0 and halt=1; else 1.
REQ-019 an_n, seg_n, dp_n SHALL be registered: they reflect idx/data_q/halt of the previous cycle (1-cycle latency).
REQ-020 an_n SHALL have exactly one bit low in every cycle after the first post-reset edge.
REQ-021 freeze asserted mid-frame SHALL NOT stop scanning; only the frame load is suppressed.

Reset
REQ-022 While rst=1: prescaler=0, idx=0, data_q=0, an_n=FF, seg_n=7F, dp_n=1, immediately (asynchronous).
REQ-023 First clk edge after rst release SHALL drive an_n=FE, seg_n=40 (digit 0 of zero).
REQ-024 rst asserted mid-scan SHALL abandon the frame; no partial state survives.

Structure
REQ-025 Segment patterns, blank pattern (7F) and digit-count constants SHALL live in a shared header Display.vh.
REQ-026 Hex-to-segment decode SHALL be a combinational sub-module cmb_hex7seg (nibble in, 7-bit seg_n out).
REQ-027 Prescaler, idx, frame latch and output registers SHALL reside in syn_seg_scan.

Verification (ScanDiv=4)
REQ-028 rst pulse mid-scan -> same cycle an_n=FF, seg_n=7F, dp_n=1; next edge after release an_n=FE, seg_n=40.
REQ-029 data=12345678 held over two frames -> in second frame digit 0 seg_n=00, digit 7 seg_n=79; each an_n value held 4 cycles.
REQ-030 data=000000A0, LeadBlank=1 -> digit0 40, digit1 08, digits 2-7 7F.
REQ-031 data 11111111 -> 22222222 switched at idx=3 -> remaining digits of frame still 79; next frame 24.
REQ-032 halt=1 -> dp_n=0 exactly while an_n=FE, 1 otherwise.
REQ-033 freeze=1 across frame boundary with new data -> data_q unchanged, scanning continues; freeze=0 -> new data from next boundary.

Source files
------------

// File: rtl/syn_seg_scan_pkg.sv
// Shared display constants: digit count, blank pattern and active-low hex segment table.
package syn_seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned NumDigits = 8;
  localparam int unsigned IdxW      = 3;
  localparam seg_t        SegBlank  = 7'h7F;

  // Index is the nibble value; bit0 = a ... bit6 = g, low = lit.
  localparam seg_t SegHex [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/syn_seg_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module cmb_hex7seg
  import syn_seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SegHex[i_nibble];
  end

endmodule

// File: rtl/syn_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-frame latching and leading-zero blanking.
module syn_seg_scan
  import syn_seg_scan_pkg::*;
#(
  parameter int unsigned ScanDiv   = 50000,
  parameter bit          LeadBlank = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        halt,
  input  logic        freeze,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam logic [15:0] TickAt = 16'(ScanDiv - 1);

  logic [15:0]     r_presc;
  logic [IdxW-1:0] r_idx;
  logic [31:0]     r_data_q;

  logic            w_tick;
  logic [4:0]      w_shift;
  logic [3:0]      w_nibble;
  logic [31:0]     w_upper;
  logic            w_blank;
  logic [6:0]      w_seg_dec;

  always_comb begin
    w_tick   = (r_presc == TickAt);
    w_shift  = {r_idx, 2'b00};
    w_nibble = r_data_q[w_shift +: 4];
    w_upper  = r_data_q >> w_shift;
    // Digit 0 always shows, so a zero frame still displays "0".
    w_blank  = LeadBlank && (r_idx != '0) && (w_upper == '0);
  end

  cmb_hex7seg u_dec (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_data_q <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 1'b1;
        // Frame latch only at the 7->0 wrap keeps a frame from tearing.
        if ((r_idx == IdxW'(NumDigits - 1)) && !freeze) begin
          r_data_q <= data;
        end
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n  <= '1;
      seg_n <= SegBlank;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= ~(8'd1 << r_idx);
      seg_n <= w_blank ? SegBlank : w_seg_dec;
      dp_n  <= ~((r_idx == '0) && halt);
    end
  end

endmodule
